// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (boot / run / hold)
//   INST_W        : instruction and address width
//   NOP_INST      : word loaded into IF/ID for a bubble
//   if_id_t       : IF/ID pipeline register contents {inst, pc4, valid}
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] pc4;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with flush / hold / load control.
// Priority: flush (bubble, pc4 kept) > hold (keep all) > load d_i.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset (clears to zero)
//   hold_i        : keep current contents
//   flush_i       : replace contents with a bubble
//   d_i           : value to load when neither hold nor flush
//   q_o           : registered contents
// ----------------------------------------------------------------------------
import fetch_pkg::*;

module if_id_reg (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   hold_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (flush_i) begin
            // pc4 deliberately keeps its old value on a bubble
            q_d.inst  = NOP_INST;
            q_d.valid = 1'b0;
        end else if (!hold_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// IF stage: PC register, next-PC selection, fetch FSM and the IF/ID register.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   imem_addr / imem_inst    : async-read instruction memory (addr = PC)
//   stall                    : hold PC and IF/ID
//   redirect / redirect_pc   : load target (word-aligned) as next PC, squash IF/ID
//   flush                    : squash IF/ID into a bubble
//   if_id_inst/pc4/valid     : IF/ID register outputs
//   perf_fetched/bubbles     : event counters, present only with FETCH_PERF_EN
// Build option: define FETCH_PERF_EN to add the two performance counters.
// ----------------------------------------------------------------------------
import fetch_pkg::*;

module instruction_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [INST_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [INST_W-1:0] redirect_pc,
    input  logic              flush,
    output logic [INST_W-1:0] if_id_inst,
    output logic [INST_W-1:0] if_id_pc4,
    output logic              if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);

    fetch_state_t      state_q, state_d;
    logic [INST_W-1:0] pc_q, pc_d, pc_plus;
    logic              hold_pc, squash;
    if_id_t            ifid_d, ifid_q;
    logic              unused_rpc_lsb;

    // Target is forced word-aligned, so the low bits are never consumed.
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    assign pc_plus = pc_q + 32'(PC_STEP);

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_BOOT;
        else     state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = stall ? S_HOLD : S_RUN;
            S_RUN:   if (stall && !redirect) state_d = S_HOLD;
            S_HOLD:  if (!stall || redirect) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    // ---- FSM: outputs / datapath control ----
    // The boot cycle always fetches PC_RESET, so stall is ignored there.
    always_comb begin
        hold_pc = stall && (state_q != S_BOOT);
        squash  = flush || redirect;
        if (redirect)     pc_d = {redirect_pc[31:2], 2'b00};
        else if (hold_pc) pc_d = pc_q;
        else              pc_d = pc_plus;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= PC_RESET;
        else     pc_q <= pc_d;
    end

    assign imem_addr = pc_q;

    always_comb begin
        ifid_d.inst  = imem_inst;
        ifid_d.pc4   = pc_plus;
        ifid_d.valid = 1'b1;
    end

    if_id_reg u_if_id (
        .clk_i   (clk),
        .rst_i   (rst),
        .hold_i  (hold_pc),
        .flush_i (squash),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign if_id_inst  = ifid_q.inst;
    assign if_id_pc4   = ifid_q.pc4;
    assign if_id_valid = ifid_q.valid;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d, bubbles_q, bubbles_d;

    // Held IF/ID contents count as neither a fetch nor a bubble.
    always_comb begin
        fetched_d = fetched_q;
        bubbles_d = bubbles_q;
        if (squash)        bubbles_d = bubbles_q + 32'd1;
        else if (!hold_pc) fetched_d = fetched_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed table, hand-written
// corner sequences, then random stimulus against a behavioural model.
import fetch_pkg::*;

module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr, imem_inst;
    logic        stall, redirect, flush;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_inst, if_id_pc4;
    logic        if_id_valid;
    logic [31:0] w_addr, w_inst, w_ifi, w_pc4;
    logic        w_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles, w_pf, w_pb;
`endif

    int checks   = 0;
    int failures = 0;

    // Memory contents are a function of the decoded 10-bit address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'hA000_0000 | {22'd0, a[9:2], 2'b00};
    endfunction

    assign imem_inst = memword(imem_addr);
    assign w_inst    = memword(w_addr);

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    instruction_fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_inst(w_inst),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0), .flush(1'b0),
        .if_id_inst(w_ifi), .if_id_pc4(w_pc4), .if_id_valid(w_valid)
`ifdef FETCH_PERF_EN
        , .perf_fetched(w_pf), .perf_bubbles(w_pb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // ---- behavioural model ----
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid, m_boot;
    logic [31:0] m_fet, m_bub;

    task automatic model_reset();
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_boot = 1'b1; m_fet = 0; m_bub = 0;
    endtask

    // One rising edge with the given requests.
    task automatic model_step(input logic s, input logic r, input logic f, input logic [31:0] rpc);
        logic es;
        es = s && !m_boot;
        if (r || f) begin
            m_inst = 32'h0; m_valid = 1'b0; m_bub = m_bub + 1;
        end else if (!es) begin
            m_inst = memword(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1; m_fet = m_fet + 1;
        end
        if (r)        m_pc = rpc & 32'hFFFF_FFFC;
        else if (!es) m_pc = m_pc + 4;
        m_boot = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".addr"},  imem_addr, m_pc);
        chk({tag, ".inst"},  if_id_inst, m_inst);
        chk({tag, ".pc4"},   if_id_pc4, m_pc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_EN
        chk({tag, ".pfet"},  perf_fetched, m_fet);
        chk({tag, ".pbub"},  perf_bubbles, m_bub);
`endif
    endtask

    // Apply requests, take one edge, sample 1 time unit later.
    task automatic cycle(input logic s, input logic r, input logic f, input logic [31:0] rpc);
        stall = s; redirect = r; flush = f; redirect_pc = rpc;
        @(posedge clk);
        model_step(s, r, f, rpc);
        #1;
    endtask

    typedef struct {
        logic        s, r, f;
        logic [31:0] rpc;
        logic [31:0] e_addr, e_inst, e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{0,0,0, 32'h0,  32'h04, memword(32'h00), 32'h04, 1};
        vt[1]  = '{0,0,0, 32'h0,  32'h08, memword(32'h04), 32'h08, 1};
        vt[2]  = '{1,0,0, 32'h0,  32'h08, memword(32'h04), 32'h08, 1};
        vt[3]  = '{1,0,0, 32'h0,  32'h08, memword(32'h04), 32'h08, 1};
        vt[4]  = '{0,0,0, 32'h0,  32'h0C, memword(32'h08), 32'h0C, 1};
        vt[5]  = '{0,0,0, 32'h0,  32'h10, memword(32'h0C), 32'h10, 1};
        vt[6]  = '{0,1,0, 32'h13, 32'h10, 32'h0,           32'h10, 0};
        vt[7]  = '{0,0,0, 32'h0,  32'h14, memword(32'h10), 32'h14, 1};
        vt[8]  = '{1,1,1, 32'h0,  32'h00, 32'h0,           32'h14, 0};
        vt[9]  = '{0,0,0, 32'h0,  32'h04, memword(32'h00), 32'h04, 1};
        vt[10] = '{0,0,1, 32'h0,  32'h08, 32'h0,           32'h04, 0};
        vt[11] = '{1,0,1, 32'h0,  32'h08, 32'h0,           32'h04, 0};

        stall = 0; redirect = 0; flush = 0; redirect_pc = 0;
        rst = 1'b1;
        model_reset();
        #12;
        chk("rst.addr",  imem_addr, 32'h0);
        chk("rst.inst",  if_id_inst, 32'h0);
        chk("rst.pc4",   if_id_pc4, 32'h0);
        chk("rst.valid", {31'd0, if_id_valid}, 32'h0);
        chk("wrap.rst.addr", w_addr, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_EN
        chk("rst.pfet", perf_fetched, 32'h0);
        chk("rst.pbub", perf_bubbles, 32'h0);
`endif
        rst = 1'b0;

        // directed table
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].s, vt[i].r, vt[i].f, vt[i].rpc);
            chk($sformatf("tbl%0d.addr", i),  imem_addr, vt[i].e_addr);
            chk($sformatf("tbl%0d.inst", i),  if_id_inst, vt[i].e_inst);
            chk($sformatf("tbl%0d.pc4", i),   if_id_pc4, vt[i].e_pc4);
            chk($sformatf("tbl%0d.valid", i), {31'd0, if_id_valid}, {31'd0, vt[i].e_valid});
`ifdef FETCH_PERF_EN
            chk($sformatf("tbl%0d.pfet", i), perf_fetched, m_fet);
            chk($sformatf("tbl%0d.pbub", i), perf_bubbles, m_bub);
`endif
            if (i == 0) begin
                chk("wrap.e1.addr", w_addr, 32'h0000_0000);
                chk("wrap.e1.pc4",  w_pc4, 32'h0000_0000);
                chk("wrap.e1.inst", w_ifi, memword(32'hFFFF_FFFC));
            end
            if (i == 1) chk("wrap.e2.addr", w_addr, 32'h0000_0004);
        end

        // reset asserted in the middle of a stall, between edges
        cycle(1, 0, 0, 0);
        chk_model("prestall");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_model("midrst");
        chk("midrst.state", 32'(dut.state_q), 32'(S_BOOT));
        #2 rst = 1'b0;
        // boot edge fetches PC_RESET even with stall still high
        cycle(1, 0, 0, 0);
        chk("boot.addr", imem_addr, 32'h4);
        chk("boot.inst", if_id_inst, memword(32'h0));
        chk("boot.valid", {31'd0, if_id_valid}, 32'h1);
        cycle(1, 0, 0, 0);
        chk_model("boot.hold");

        // random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            logic s, r, f;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 9) == 0);
            cycle(s, r, f, $urandom);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
